// File: rtl/debug_scan_monitor_if.sv
// Bundles the config strobe, live neuron state and registered debug stream of
// debug_scan_monitor. The master drives stimulus and the slave is the monitor.
interface debug_scan_monitor_if #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned PW   = 6,
  parameter int unsigned OW   = 8,
  parameter int unsigned SW   = 8
) ();
  logic                 en;
  logic [7:0]           cfg_in;
  logic [N_CH*PW-1:0]   membrane_potentials;
  logic [SW-1:0]        spikes;
  logic [OW-1:0]        debug_output;
  logic                 debug_valid;
  logic                 frame_start;
  logic                 snap_busy;

  modport master (
    output en, cfg_in, membrane_potentials, spikes,
    input  debug_output, debug_valid, frame_start, snap_busy
  );

  modport slave (
    input  en, cfg_in, membrane_potentials, spikes,
    output debug_output, debug_valid, frame_start, snap_busy
  );
endinterface

// File: rtl/debug_scan_monitor.sv
// Debug tap for a spiking layer: direct channel/spike view, round-robin scan,
// spike-change reporting and a frozen snapshot stream, all with one-cycle latency.
module debug_scan_monitor #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned PW   = 6,
  parameter int unsigned OW   = 8,
  parameter int unsigned SW   = 8
) (
  input logic                 clk,
  input logic                 rst,
  debug_scan_monitor_if.slave bus
);
  localparam int unsigned PtrW = $clog2(N_CH);

  typedef enum logic [1:0] {
    ModeDirect = 2'b00,
    ModeScan   = 2'b01,
    ModeSpike  = 2'b10,
    ModeSnap   = 2'b11
  } mode_e;

  logic [7:0]      cfg_q, cfg_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [SW-1:0]   spk_prev_q;
  logic [OW-1:0]   out_q, out_d;
  logic            valid_q, valid_d;
  logic            frame_q, frame_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   snap_q [N_CH];
  logic [PW-1:0]   pot [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign pot[i] = bus.membrane_potentials[i*PW +: PW];
  end

  mode_e           mode;
  logic [5:0]      idx;
  logic            load;
  logic            capture;
  logic            ptr_last;
  logic [PtrW-1:0] ptr_inc;

  assign mode     = mode_e'(cfg_q[7:6]);
  assign idx      = cfg_q[5:0];
  assign load     = bus.en;
  assign capture  = bus.en && (bus.cfg_in[7:6] == 2'b11);
  assign ptr_last = (ptr_q == PtrW'(N_CH - 1));
  assign ptr_inc  = ptr_last ? '0 : ptr_q + 1'b1;

  always_comb begin
    cfg_d   = load ? bus.cfg_in : cfg_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    valid_d = 1'b0;
    frame_d = 1'b0;
    busy_d  = busy_q;
    unique case (mode)
      ModeDirect: begin
        valid_d = 1'b1;
        out_d   = (32'(idx) < N_CH) ? OW'(pot[idx[PtrW-1:0]]) : OW'(bus.spikes);
      end
      ModeScan: begin
        out_d   = OW'(pot[ptr_q]);
        valid_d = 1'b1;
        frame_d = (ptr_q == '0);
        ptr_d   = ptr_inc;
      end
      ModeSpike: begin
        out_d   = OW'(bus.spikes);
        valid_d = (bus.spikes != spk_prev_q);
      end
      ModeSnap: begin
        // Once the stream has drained, output holds and valid stays low.
        if (busy_q) begin
          out_d   = OW'(snap_q[ptr_q]);
          valid_d = 1'b1;
          frame_d = (ptr_q == '0);
          ptr_d   = ptr_inc;
          if (ptr_last) busy_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A load always restarts; only a mode-11 load (re)starts a snapshot stream.
    if (load) begin
      ptr_d  = '0;
      busy_d = capture;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q      <= '0;
      ptr_q      <= '0;
      spk_prev_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < N_CH; i++) snap_q[i] <= '0;
    end else begin
      cfg_q      <= cfg_d;
      ptr_q      <= ptr_d;
      spk_prev_q <= bus.spikes;
      out_q      <= out_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      if (capture) begin
        for (int i = 0; i < N_CH; i++) snap_q[i] <= pot[i];
      end
    end
  end

  assign bus.debug_output = out_q;
  assign bus.debug_valid  = valid_q;
  assign bus.frame_start  = frame_q;
  assign bus.snap_busy    = busy_q;
endmodule
